// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated 16/32-bit data memory responder for the memory stage.
// Define DMEM_PROTECT_EN to suppress writes touching words below PROT_TOP and flag fault.
module dmem_responder #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 2,
  parameter int PROT_TOP    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_wide,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              stall,
  output logic              fault
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CW    = $clog2(WAIT_STATES + 2);
`ifdef DMEM_PROTECT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, WAIT, LO, HI, RESP} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              write_q, write_d;
  logic              wide_q, wide_d;
  logic              fault_q, fault_d;
  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] req_addr_hi, addr_hi, wa;
  logic [15:0]       wd;
  logic              we, prot;
  assign req_addr_hi = req_addr + ADDR_W'(1);
  assign addr_hi     = addr_q + ADDR_W'(1);
  // Protection is decided once at accept so both words of a wide write are suppressed together
  assign prot = PROT_EN & req_write &
                ((32'(req_addr) < PROT_TOP) | (req_wide & (32'(req_addr_hi) < PROT_TOP)));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    write_d = write_q;
    wide_d  = wide_q;
    fault_d = fault_q;
    we      = 1'b0;
    wa      = addr_q;
    wd      = wdata_q[15:0];
    case (state_q)
      IDLE: if (req_valid) begin
        addr_d  = req_addr;
        wdata_d = req_wdata;
        write_d = req_write;
        wide_d  = req_wide;
        fault_d = prot;
        rdata_d = '0;
        cnt_d   = CW'(WAIT_STATES);
        state_d = (WAIT_STATES == 0) ? LO : WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q <= CW'(1)) ? LO : WAIT;
      end
      LO: begin
        we      = write_q & ~fault_q;
        rdata_d[15:0] = write_q ? 16'h0 : mem[addr_q];
        state_d = wide_q ? HI : RESP;
      end
      HI: begin
        we      = write_q & ~fault_q;
        wa      = addr_hi;
        wd      = wdata_q[31:16];
        rdata_d[31:16] = write_q ? 16'h0 : mem[addr_hi];
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
      wide_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      write_q <= write_d;
      wide_q  <= wide_d;
      fault_q <= fault_d;
    end
  end
  // Array is deliberately outside reset; we already drops when rst forces IDLE
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign fault     = rsp_valid & fault_q;
  assign stall     = req_valid & ~rsp_valid;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized checks of dmem_responder against a transaction-level model.
module tb_dmem_responder;
  localparam int AW = 12;
  localparam int WS = 2;
  localparam int PT = 32;
  localparam int DEPTH = 2 ** AW;
`ifdef DMEM_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif
  logic          clk, rst, req_valid, req_ready, req_write, req_wide;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata, rsp_rdata;
  logic          rsp_valid, stall, fault;
  int checks = 0;
  int fails = 0;

  dmem_responder #(.ADDR_W(AW), .WAIT_STATES(WS), .PROT_TOP(PT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_wide(req_wide), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .stall(stall), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding access, memory effect when its last word completes
  logic [15:0]   mm [DEPTH];
  bit            known [DEPTH];
  bit            busy = 0;
  int            rem = 0;
  logic          m_wr, m_wide, m_fault;
  logic [AW-1:0] m_a, m_ah;
  logic [31:0]   m_wd, m_rd, m_rmask;

  function automatic bit prot_hit(input logic wr, input logic wide, input logic [AW-1:0] a);
    logic [AW-1:0] h;
    h = a + 1'b1;
    return PROT && wr && ((int'(a) < PT) || (wide && int'(h) < PT));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      if (busy && m_wr && m_wide && rem == 1 && !m_fault) begin
        mm[m_a] = m_wd[15:0];
        known[m_a] = 1'b1;
      end
      busy = 0;
      rem = 0;
    end else if (busy) begin
      if (rem == 0) busy = 0;
      else begin
        rem--;
        if (rem == 0 && m_wr && !m_fault) begin
          mm[m_a] = m_wd[15:0];
          known[m_a] = 1'b1;
          if (m_wide) begin
            mm[m_ah] = m_wd[31:16];
            known[m_ah] = 1'b1;
          end
        end
      end
    end else if (req_valid) begin
      m_wr = req_write;
      m_wide = req_wide;
      m_a = req_addr;
      m_ah = req_addr + 1'b1;
      m_wd = req_wdata;
      m_fault = prot_hit(req_write, req_wide, req_addr);
      m_rd = '0;
      m_rmask = 32'hFFFF_FFFF;
      if (!req_write) begin
        m_rd[15:0] = mm[m_a];
        m_rmask[15:0] = known[m_a] ? 16'hFFFF : 16'h0;
        if (req_wide) begin
          m_rd[31:16] = mm[m_ah];
          m_rmask[31:16] = known[m_ah] ? 16'hFFFF : 16'h0;
        end
      end
      rem = WS + (req_wide ? 2 : 1);
      busy = 1;
    end
  end

  always @(negedge clk) begin
    check("req_ready", req_ready, !busy);
    check("rsp_valid", rsp_valid, busy && rem == 0);
    check("stall", stall, req_valid && !(busy && rem == 0));
    if (busy && rem == 0) begin
      check("rsp_rdata", rsp_rdata & m_rmask, m_rd & m_rmask);
      check("fault", fault, m_fault);
    end
  end

  task automatic xfer(input logic wr, input logic wide, input logic [AW-1:0] a,
                      input logic [31:0] d, input bit scr,
                      output logic [31:0] rd, output logic flt, output int lat);
    bit got;
    req_valid = 1'b1;
    req_write = wr;
    req_wide = wide;
    req_addr = a;
    req_wdata = d;
    #1 check("stall_accept", stall, 1'b1);
    @(posedge clk);
    lat = 0;
    rd = '0;
    flt = 1'b0;
    got = 0;
    while (!got && lat < 20) begin
      @(posedge clk);
      #1 lat++;
      if (rsp_valid) begin
        got = 1;
        rd = rsp_rdata;
        flt = fault;
        check("stall_rsp", stall, 1'b0);
      end else if (scr) begin
        req_addr = AW'($urandom);
        req_wdata = $urandom;
      end
    end
    check("rsp_timeout", got, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  logic [31:0]   rd;
  logic          flt;
  int            lat, sel, gap;
  logic          w, wd;
  logic [AW-1:0] a;

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_wide = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_fault", fault, 1'b0);
    check("rst_ready", req_ready, 1'b1);
    check("rst_rsp", rsp_valid, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    xfer(1'b1, 1'b0, 12'h100, 32'h0000BEEF, 0, rd, flt, lat);
    check("nw_lat", lat, 3);
    check("nw_rdata", rd, 32'h0);
    xfer(1'b0, 1'b0, 12'h100, 32'h0, 0, rd, flt, lat);
    check("nr_rdata", rd, 32'h0000BEEF);
    xfer(1'b1, 1'b1, 12'h7FE, 32'h12345678, 0, rd, flt, lat);
    check("ww_lat", lat, 4);
    xfer(1'b0, 1'b1, 12'h7FE, 32'h0, 1, rd, flt, lat);
    check("wr_rdata", rd, 32'h12345678);
    xfer(1'b0, 1'b0, 12'h7FF, 32'h0, 0, rd, flt, lat);
    check("hi_word", rd, 32'h00001234);
    xfer(1'b1, 1'b1, 12'hFFF, 32'hAAAA5555, 0, rd, flt, lat);
`ifdef DMEM_PROTECT_EN
    check("wrap_fault", flt, 1'b1);
`else
    check("wrap_fault", flt, 1'b0);
    xfer(1'b0, 1'b0, 12'h000, 32'h0, 0, rd, flt, lat);
    check("wrap_lo0", rd, 32'h0000AAAA);
    xfer(1'b0, 1'b0, 12'hFFF, 32'h0, 0, rd, flt, lat);
    check("wrap_fff", rd, 32'h00005555);
`endif
    xfer(1'b1, 1'b0, 12'h201, 32'h00007777, 0, rd, flt, lat);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_wide = 1'b1;
    req_addr = 12'h200;
    req_wdata = 32'hCAFE0001;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    req_valid = 1'b0;
    #1 check("rst_mid_ready", req_ready, 1'b1);
    check("rst_mid_rsp", rsp_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_rsp_after_rst", rsp_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    xfer(1'b0, 1'b1, 12'h200, 32'h0, 0, rd, flt, lat);
    check("rst_partial", rd, 32'h77770001);
    xfer(1'b1, 1'b0, 12'h005, 32'h00001111, 0, rd, flt, lat);
    check("prot_fault5", flt, PROT);
    xfer(1'b1, 1'b0, 12'h020, 32'h00001111, 0, rd, flt, lat);
    check("prot_fault32", flt, 1'b0);
    xfer(1'b0, 1'b0, 12'h020, 32'h0, 0, rd, flt, lat);
    check("prot_read32", rd, 32'h00001111);
    for (int i = 0; i < 400; i++) begin
      sel = $urandom % 4;
      w = 1'($urandom);
      wd = 1'($urandom);
      a = (sel == 0) ? AW'($urandom_range(0, 63)) :
          (sel == 1) ? AW'(32'hFF0 + $urandom_range(0, 15)) :
          (sel == 2) ? AW'(32'h100 + $urandom_range(0, 15)) : AW'($urandom);
      xfer(w, wd, a, $urandom, 1'($urandom), rd, flt, lat);
      check("latency", lat, WS + (wd ? 2 : 1));
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder that serves load/store/push/pop requests issued by the pipeline's memory stage over a valid/ready request and one-cycle response handshake. It has configurable wait states and supports narrow (16-bit) and wide (32-bit, two consecutive words) transfers; wide transfers carry PC push/pop on CALL/RET/INT. The stall output freezes the pipeline while an access is outstanding.

Parameters:
ADDR_W, 12, word-address width; DEPTH = 2**ADDR_W 16-bit words
WAIT_STATES, 2, idle cycles inserted before the first word access (0 allowed)
PROT_TOP, 32, first unprotected word address; protected range is 0..PROT_TOP-1 (used only with DMEM_PROTECT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_write  in  1  1 = store/push, 0 = load/pop
req_wide  in  1  1 = 32-bit transfer (two words), 0 = 16-bit
req_addr  in  ADDR_W  word address (SP value or ALU result, selected upstream)
req_wdata  in  32  write data; narrow uses [15:0]
rsp_valid  out  1  response/ack, one-cycle pulse
rsp_rdata  out  32  read data; valid only while rsp_valid=1
stall  out  1  pipeline freeze request
fault  out  1  protection fault, qualified by rsp_valid

Behaviour:
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, fault=0, wait counter=0. Memory array contents are not cleared by rst.
- FSM states: IDLE -> WAIT -> LO -> (HI if wide) -> RESP -> IDLE.
- IDLE: req_ready=1. On an edge with req_valid=1, latch addr/wdata/write/wide. Go to WAIT with counter=WAIT_STATES, or directly to LO if WAIT_STATES=0.
- WAIT: decrement the counter each edge; go to LO when the counter reaches 1 (i.e. exactly WAIT_STATES cycles in WAIT).
- LO: access mem[addr]. Write stores wdata[15:0]; read captures into rdata[15:0]. Next state is HI if wide, else RESP.
- HI: access mem[(addr+1) mod DEPTH]. Write stores wdata[31:16]; read captures into rdata[31:16].
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- rsp_rdata on narrow reads: [31:16]=0. rsp_rdata on writes: 0.
- Latency: rsp_valid is high N cycles after the accepting edge, where N = WAIT_STATES+1 (narrow) or WAIT_STATES+2 (wide).
- req_ready=0 in every state except IDLE. req_valid outside IDLE is ignored; there is no queueing.
- stall = req_valid & ~rsp_valid (combinational). The requester holds the request stable until rsp_valid; the pipeline advances on the rsp_valid cycle. A request present in the following cycle is treated as new.
- Address arithmetic is modulo DEPTH. A wide access at DEPTH-1 uses DEPTH-1 then 0.
- Reset mid-operation: return to IDLE immediately and drop rsp_valid. Words already written in LO persist. A wide write interrupted before HI leaves only the low word written.
- Back-to-back requests: at best one request per N+1 cycles, because of the RESP->IDLE turnaround.

Optional Feature:
DMEM_PROTECT_EN. When defined, a write whose low or high word address is < PROT_TOP is suppressed (memory unchanged) and fault=1 together with rsp_valid. Reads are unaffected. When not defined, fault is tied 0 and all writes proceed.

Test Plan:
- Narrow write then read, WAIT_STATES=2: write addr 0x100, data 0x0000BEEF -> rsp_valid 3 cycles after accept, rdata=0. Then read 0x100 -> rsp_rdata=0x0000BEEF.
- Wide push/pop: write addr 0x7FE, data 0x12345678 -> mem[0x7FE]=0x5678, mem[0x7FF]=0x1234, ack after 4 cycles. Wide read of 0x7FE -> 0x12345678.
- Wrap: wide write at 0xFFF, data 0xAAAA5555 -> mem[0xFFF]=0x5555, mem[0x000]=0xAAAA.
- Stall/ready: hold req_valid through a read with WAIT_STATES=0 -> stall=1 on the accept cycle, stall=0 on the rsp_valid cycle, req_ready=0 from accept until IDLE. A second request presented mid-access is not accepted until the state returns to IDLE.
- Reset mid-wide-write: assert rst while in HI of a write of 0xCAFE0001 to 0x200 -> rsp_valid never asserts, mem[0x200]=0x0001, mem[0x201] unchanged, req_ready=1 immediately.
- With DMEM_PROTECT_EN: narrow write to addr 5, data 0x1111 -> fault=1 with rsp_valid, mem[5] unchanged. Write to addr 32 -> fault=0, stored.
